// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment codes, digit count and slot index type for the six-digit
// multiplexed 7-segment scan driver.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] slot_idx_t;

    localparam slot_idx_t LAST_SLOT = 3'(NUM_DIGITS - 1);

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decode; non-decimal
// nibbles show a dash so corrupt counter values are visible on the display.
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit hh.mm.ss scan driver with per-slot blanking and a once-per-frame
// atomic snapshot of the BCD counters. Optional blinking: SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sec_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] hour_bcd,
    input  logic [2:0] blink_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc_q, presc_d;
    slot_idx_t     idx_q, idx_d;
    logic [23:0]   snap_q, snap_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fs_q;

    logic          slot_end, frame_end, blank_win, digit_off;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;

    assign slot_end  = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_q == LAST_SLOT);
    assign blank_win = (presc_q < PW'(BLANK_CYCLES));

    always_comb begin
        nib = snap_q[3:0];
        case (idx_q)
            3'd1:    nib = snap_q[7:4];
            3'd2:    nib = snap_q[11:8];
            3'd3:    nib = snap_q[15:12];
            3'd4:    nib = snap_q[19:16];
            3'd5:    nib = snap_q[23:20];
            default: nib = snap_q[3:0];
        endcase
    end

    bcd_to_seg7 u_dec (
        .nibble_i (nib),
        .seg_o    (dec_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt_q;
    logic          phase_q;
    logic [2:0]    bsel_q;
    logic          grp_sel;

    // Slot pairs map to groups: 0-1 sec, 2-3 min, 4-5 hour.
    always_comb begin
        case (idx_q[2:1])
            2'd0:    grp_sel = bsel_q[0];
            2'd1:    grp_sel = bsel_q[1];
            default: grp_sel = bsel_q[2];
        endcase
    end

    assign digit_off = phase_q & grp_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            bsel_q  <= '0;
        end else if (frame_end) begin
            bsel_q <= blink_sel;
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink;
    assign unused_blink = ^blink_sel;
    assign digit_off    = 1'b0;
`endif

    always_comb begin
        presc_d = slot_end ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_SLOT) ? '0 : idx_q + 3'd1;
        end
        snap_d = frame_end ? {hour_bcd, min_bcd, sec_bcd} : snap_q;

        // Decode of the current state lands on the outputs one cycle later.
        an_d  = ~(6'b000001 << idx_q);
        seg_d = dec_seg;
        dp_d  = ~((idx_q == 3'd2) || (idx_q == 3'd4));
        if (blank_win || digit_off) begin
            an_d  = '1;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= frame_end;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule
